// File: rtl/ssd_pkg.sv
// Shared constants and arbiter state encoding for the SSD scan scheduler.
package ssd_pkg;
  localparam int DIGIT_SLOTS = 4;
  localparam int SLOT_W      = 2;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_SRC0 = 2'b01;
  localparam logic [1:0] GNT_SRC1 = 2'b10;

  typedef enum logic [1:0] {ARB_IDLE, ARB_OWN0, ARB_OWN1} arb_state_t;

  function automatic logic [1:0] gnt_of(arb_state_t s);
    case (s)
      ARB_OWN0: gnt_of = GNT_SRC0;
      ARB_OWN1: gnt_of = GNT_SRC1;
      default:  gnt_of = GNT_NONE;
    endcase
  endfunction
endpackage

// File: rtl/ssd_prescaler.sv
// Digit-slot prescaler: free-running count while enabled, terminal-count tick,
// and the start-of-slot blanking window.
module ssd_prescaler #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick,
  output logic in_blank
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] TC = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (en)
      cnt <= (cnt == TC) ? '0 : cnt + 1'b1;
  end

  assign tick     = en & (cnt == TC);
  // Derived straight from the count register so it flips on the same edge as the slot index.
  assign in_blank = (32'(cnt) < 32'(BLANK_CYC));
endmodule

// File: rtl/ssd_scan_sched.sv
// SSD scan scheduler: slot sequencing, frame-boundary arbitration between two
// digit sources, and shadow latching of the owner's digits.
module ssd_scan_sched
  import ssd_pkg::*;
#(
  parameter int REFRESH_DIV     = 100000,
  parameter int BLANK_CYC       = 1000,
  parameter int MIN_HOLD_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [1:0]  req,
  input  logic [15:0] src0_digits,
  input  logic [15:0] src1_digits,
  output logic [1:0]  gnt,
  output logic [1:0]  ssd_ctl_en,
  output logic [3:0]  in3,
  output logic [3:0]  in2,
  output logic [3:0]  in1,
  output logic [3:0]  in0,
  output logic        blank,
  output logic        frame_done
);
  localparam int HW = (MIN_HOLD_FRAMES < 1) ? 1 : $clog2(MIN_HOLD_FRAMES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MIN_HOLD_FRAMES);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(DIGIT_SLOTS - 1);

  logic              tick, in_blank, frame_end;
  logic [SLOT_W-1:0] slot;
  arb_state_t        st, st_nx;
  logic [HW-1:0]     hold, hold_inc, hold_nx;
  logic              last1;
  logic [15:0]       digits_nx;

  ssd_prescaler #(
    .REFRESH_DIV(REFRESH_DIV),
    .BLANK_CYC  (BLANK_CYC)
  ) u_presc (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .tick    (tick),
    .in_blank(in_blank)
  );

  assign frame_end = tick & (slot == LAST_SLOT);
  // hold_inc counts the frame that is ending, so an owner gets MIN_HOLD_FRAMES full frames.
  assign hold_inc  = (hold >= HOLD_MAX) ? HOLD_MAX : hold + 1'b1;

  always_comb begin
    st_nx = st;
    case (st)
      ARB_IDLE: begin
        if (req == 2'b11)  st_nx = last1 ? ARB_OWN0 : ARB_OWN1;
        else if (req[0])   st_nx = ARB_OWN0;
        else if (req[1])   st_nx = ARB_OWN1;
      end
      ARB_OWN0: begin
        if (!req[0])                          st_nx = req[1] ? ARB_OWN1 : ARB_IDLE;
        else if (req[1] && hold_inc >= HOLD_MAX) st_nx = ARB_OWN1;
      end
      ARB_OWN1: begin
        if (!req[1])                          st_nx = req[0] ? ARB_OWN0 : ARB_IDLE;
        else if (req[0] && hold_inc >= HOLD_MAX) st_nx = ARB_OWN0;
      end
      default: st_nx = ARB_IDLE;
    endcase
  end

  always_comb begin
    hold_nx = ((st_nx != st) || (st_nx == ARB_IDLE)) ? '0 : hold_inc;
    case (st_nx)
      ARB_OWN0: digits_nx = src0_digits;
      ARB_OWN1: digits_nx = src1_digits;
      default:  digits_nx = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot       <= '0;
      st         <= ARB_IDLE;
      gnt        <= GNT_NONE;
      hold       <= '0;
      last1      <= 1'b1;
      frame_done <= 1'b0;
      {in3, in2, in1, in0} <= '0;
    end else begin
      frame_done <= frame_end;
      if (tick) slot <= slot + 1'b1;
      if (frame_end) begin
        st   <= st_nx;
        gnt  <= gnt_of(st_nx);
        hold <= hold_nx;
        if (st_nx == ARB_OWN0) last1 <= 1'b0;
        if (st_nx == ARB_OWN1) last1 <= 1'b1;
        {in3, in2, in1, in0} <= digits_nx;
      end
    end
  end

  assign ssd_ctl_en = slot;
  assign blank      = !en | (gnt == GNT_NONE) | in_blank;
endmodule

// File: tb/tb_ssd_scan_sched.sv
// Self-checking bench for ssd_scan_sched with REFRESH_DIV=8, BLANK_CYC=2, MIN_HOLD_FRAMES=2.
module tb_ssd_scan_sched;
  localparam int DIV = 8, BLK = 2, FRAME = 32;

  logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [15:0] src0 = '0, src1 = '0;
  logic [1:0]  gnt, ssd_ctl_en;
  logic [3:0]  in3, in2, in1, in0;
  logic        blank, frame_done;

  ssd_scan_sched #(.REFRESH_DIV(DIV), .BLANK_CYC(BLK), .MIN_HOLD_FRAMES(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .src0_digits(src0), .src1_digits(src1),
    .gnt(gnt), .ssd_ctl_en(ssd_ctl_en),
    .in3(in3), .in2(in2), .in1(in1), .in0(in0),
    .blank(blank), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;
    logic [15:0] s0, s1;
    logic [1:0]  gnt;
    logic [15:0] dig;
  } vec_t;
  typedef struct {
    logic [1:0]  gnt;
    logic [15:0] dig;
  } exp_t;

  vec_t vt[20];
  exp_t sbq[$];
  exp_t e;

  int checks = 0, errors = 0;
  int c = 0;
  logic [1:0]  prev_gnt = 2'b00;
  logic [15:0] prev_dig = '0;
  logic        fd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One enabled clock: frame position, slot index, blanking and steady gnt/digits.
  task automatic step(output logic got_fd);
    @(posedge clk); #1;
    c++;
    got_fd = frame_done;
    chk("frame_done", {31'd0, frame_done}, {31'd0, (c % FRAME) == 0});
    chk("slot", {30'd0, ssd_ctl_en}, 32'((c % FRAME) / DIV));
    chk("blank", {31'd0, blank}, {31'd0, (prev_gnt == 2'b00) || ((c % DIV) < BLK)});
    if (!frame_done) begin
      chk("gnt_steady", {30'd0, gnt}, {30'd0, prev_gnt});
      chk("dig_steady", {16'd0, in3, in2, in1, in0}, {16'd0, prev_dig});
    end
  endtask

  task automatic wait_fd(input string name);
    logic f;
    f = 1'b0;
    for (int n = 0; n < 40 && !f; n++) step(f);
    if (!f) begin
      errors++;
      $display("FAIL %s frame_done timeout", name);
    end
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty", name);
    end else begin
      e = sbq.pop_front();
      chk({name, "_gnt"}, {30'd0, gnt}, {30'd0, e.gnt});
      chk({name, "_dig"}, {16'd0, in3, in2, in1, in0}, {16'd0, e.dig});
      prev_gnt = e.gnt;
      prev_dig = e.dig;
    end
  endtask

  task automatic chk_reset(input string name);
    chk({name, "_gnt"}, {30'd0, gnt}, 32'd0);
    chk({name, "_slot"}, {30'd0, ssd_ctl_en}, 32'd0);
    chk({name, "_dig"}, {16'd0, in3, in2, in1, in0}, 32'd0);
    chk({name, "_blank"}, {31'd0, blank}, 32'd1);
    chk({name, "_fd"}, {31'd0, frame_done}, 32'd0);
  endtask

  initial begin
    // req, src0, src1, expected gnt and latched digits after the next boundary
    vt[0]  = '{2'b01, 16'h1234, 16'hABCD, 2'b01, 16'h1234};
    vt[1]  = '{2'b11, 16'h5678, 16'hABCD, 2'b01, 16'h5678};
    vt[2]  = '{2'b11, 16'h5678, 16'hABCD, 2'b10, 16'hABCD};
    vt[3]  = '{2'b11, 16'h1111, 16'h2222, 2'b10, 16'h2222};
    vt[4]  = '{2'b11, 16'h1111, 16'h2222, 2'b01, 16'h1111};
    vt[5]  = '{2'b01, 16'h1111, 16'h2222, 2'b01, 16'h1111};
    vt[6]  = '{2'b00, 16'h1111, 16'h2222, 2'b00, 16'h0000};
    vt[7]  = '{2'b00, 16'h9999, 16'h8888, 2'b00, 16'h0000};
    vt[8]  = '{2'b11, 16'h3333, 16'h4444, 2'b10, 16'h4444};
    vt[9]  = '{2'b01, 16'h3333, 16'h4444, 2'b01, 16'h3333};
    vt[10] = '{2'b10, 16'h3333, 16'h4444, 2'b10, 16'h4444};
    vt[11] = '{2'b11, 16'h3333, 16'h4444, 2'b10, 16'h4444};
    vt[12] = '{2'b01, 16'h3333, 16'h4444, 2'b01, 16'h3333};
    vt[13] = '{2'b11, 16'h3333, 16'h4444, 2'b01, 16'h3333};
    vt[14] = '{2'b10, 16'h3333, 16'h4444, 2'b10, 16'h4444};
    vt[15] = '{2'b00, 16'h3333, 16'h4444, 2'b00, 16'h0000};
    vt[16] = '{2'b11, 16'h3333, 16'h4444, 2'b01, 16'h3333};
    vt[17] = '{2'b01, 16'h3333, 16'h4444, 2'b01, 16'h3333};
    vt[18] = '{2'b01, 16'h3333, 16'h4444, 2'b01, 16'h3333};
    vt[19] = '{2'b11, 16'h3333, 16'h4444, 2'b10, 16'h4444};

    repeat (2) @(posedge clk);
    #1 chk_reset("reset");

    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    c     = 0;
    for (int k = 0; k < 2 * FRAME; k++) step(fd);

    for (int i = 0; i < 20; i++) begin
      repeat (5) step(fd);
      req  = vt[i].req;
      src0 = vt[i].s0;
      src1 = vt[i].s1;
      sbq.push_back('{vt[i].gnt, vt[i].dig});
      wait_fd($sformatf("row%0d", i));
    end

    // Freeze mid-slot: owner 1 alone keeps the display through the next boundary.
    req = 2'b10;
    repeat (3) step(fd);
    en = 1'b0;
    #1 chk("en0_blank_now", {31'd0, blank}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("en0_slot", {30'd0, ssd_ctl_en}, 32'd0);
      chk("en0_fd", {31'd0, frame_done}, 32'd0);
      chk("en0_blank", {31'd0, blank}, 32'd1);
      chk("en0_gnt", {30'd0, gnt}, {30'd0, prev_gnt});
    end
    en = 1'b1;
    #1 chk("en1_blank_resume", {31'd0, blank}, 32'd0);
    sbq.push_back('{2'b10, 16'h4444});
    wait_fd("resume");
    chk("resume_len", 32'(c % FRAME), 32'd0);

    // Asynchronous reset in the middle of slot 1.
    repeat (10) step(fd);
    #2 rst_n = 1'b0;
    #1 chk_reset("midreset");

    req  = 2'b01;
    src0 = 16'hABCD;
    sbq.push_back('{2'b01, 16'hABCD});
    @(negedge clk);
    rst_n    = 1'b1;
    c        = 0;
    prev_gnt = 2'b00;
    prev_dig = '0;
    wait_fd("first_grant");
    chk("first_grant_cyc", 32'(c), 32'(FRAME));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
